periph_bus_arbiter: RTL and testbench

- Two-master, single-outstanding arbiter and sequencer for the data-side system bus.
- Master 0 is the CPU M-stage; master 1 is a secondary master (debug/DMA port).
- Grants one master at a time, decodes the address onto DM / timer0 / timer1 / interrupt-generator selects, strobes the target for one cycle, and returns read data or an address-error response.
- Sits between the M-stage byte-enable/exception logic and the memory-mapped targets.

---
 rtl/periph_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// Two-master, single-outstanding data-bus arbiter: grant, decode, one-cycle target strobe, response.
// Define FIXED_PRIO_EN to make master 0 win every simultaneous request (otherwise round-robin).
module periph_bus_arbiter #(
  parameter logic [31:0] DM_START  = 32'h0000_0000,
  parameter logic [31:0] DM_END    = 32'h0000_2FFF,
  parameter logic [31:0] T0_START  = 32'h0000_7F00,
  parameter logic [31:0] T1_START  = 32'h0000_7F10,
  parameter logic [31:0] INT_START = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_be,
  input  logic [3:0]  m1_be,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] t_addr,
  output logic [31:0] t_wdata,
  output logic [3:0]  t_be,
  output logic        t_we,
  output logic        sel_dm,
  output logic        sel_t0,
  output logic        sel_t1,
  output logic        sel_int,
  input  logic [31:0] rd_dm,
  input  logic [31:0] rd_t0,
  input  logic [31:0] rd_t1,
  input  logic [31:0] rd_int
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        lat_id;
  logic        lat_we;
  logic [3:0]  tgt;      // {int, t1, t0, dm}, zero for an errored access

  logic        gnt0, gnt1;
  logic        g_we;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_be;
  logic [31:0] off_dm, off_t0, off_t1, off_int;
  logic        hit_dm, hit_t0, hit_t1, hit_int;
  logic        be_ok, g_err;
  logic [3:0]  g_tgt;

`ifdef FIXED_PRIO_EN
  assign gnt0 = (state == IDLE) && m0_req;
  assign gnt1 = (state == IDLE) && m1_req && !m0_req;
`else
  logic last_id;
  assign gnt0 = (state == IDLE) && m0_req && (!m1_req || last_id);
  assign gnt1 = (state == IDLE) && m1_req && (!m0_req || !last_id);
`endif

  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;
  assign g_we    = gnt1 ? m1_we    : m0_we;
  assign g_addr  = gnt1 ? m1_addr  : m0_addr;
  assign g_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign g_be    = gnt1 ? m1_be    : m0_be;

  // Offset-from-base compares keep each window check to a single unsigned test.
  always_comb begin
    off_dm  = g_addr - DM_START;
    off_t0  = g_addr - T0_START;
    off_t1  = g_addr - T1_START;
    off_int = g_addr - INT_START;
    hit_dm  = off_dm <= (DM_END - DM_START);
    hit_t0  = off_t0 < 32'd12;
    hit_t1  = off_t1 < 32'd12;
    hit_int = off_int < 32'd4;

    be_ok = 1'b0;
    case (g_be)
      4'b1111, 4'b0011, 4'b0001: be_ok = (g_addr[1:0] == 2'b00);
      4'b0010:                   be_ok = (g_addr[1:0] == 2'b01);
      4'b1100, 4'b0100:          be_ok = (g_addr[1:0] == 2'b10);
      4'b1000:                   be_ok = (g_addr[1:0] == 2'b11);
      default:                   be_ok = 1'b0;
    endcase

    g_err = !(hit_dm || hit_t0 || hit_t1 || hit_int)
         || !be_ok
         || ((hit_t0 || hit_t1 || hit_int) && (g_be != 4'b1111))
         || (g_we && ((hit_t0 && off_t0[3]) || (hit_t1 && off_t1[3])));

    g_tgt = g_err ? '0 : {hit_int, hit_t1, hit_t0, hit_dm};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel_dm     <= 1'b0;
      sel_t0     <= 1'b0;
      sel_t1     <= 1'b0;
      sel_int    <= 1'b0;
      t_we       <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_id    <= 1'b0;
      t_addr     <= '0;
      t_wdata    <= '0;
      t_be       <= '0;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      tgt        <= '0;
`ifndef FIXED_PRIO_EN
      last_id    <= 1'b1;
`endif
    end else begin
      sel_dm     <= 1'b0;
      sel_t0     <= 1'b0;
      sel_t1     <= 1'b0;
      sel_int    <= 1'b0;
      t_we       <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            lat_id  <= gnt1;
            lat_we  <= g_we;
            t_addr  <= g_addr;
            t_wdata <= g_wdata;
            t_be    <= g_be;
            tgt     <= g_tgt;
`ifndef FIXED_PRIO_EN
            last_id <= gnt1;
`endif
            // Errored requests skip the target phase and answer one cycle early.
            if (g_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_id    <= gnt1;
              resp_err   <= 1'b1;
            end else begin
              state <= ACCESS;
              {sel_int, sel_t1, sel_t0, sel_dm} <= g_tgt;
              t_we  <= g_we;
            end
          end
        end
        ACCESS: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_id    <= lat_id;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Target read data arrives the cycle after the strobe, so it is steered straight through.
  always_comb begin
    resp_rdata = '0;
    if (resp_valid && !resp_err && !lat_we)
      resp_rdata = ({32{tgt[0]}} & rd_dm) | ({32{tgt[1]}} & rd_t0)
                 | ({32{tgt[2]}} & rd_t1) | ({32{tgt[3]}} & rd_int);
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: stimulus pushes predicted responses, a monitor checks strobes and responses.
module tb_periph_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt;
  logic        resp_valid, resp_id, resp_err;
  logic [31:0] resp_rdata, t_addr, t_wdata;
  logic [3:0]  t_be;
  logic        t_we, sel_dm, sel_t0, sel_t1, sel_int;
  logic [31:0] rd_dm, rd_t0, rd_t1, rd_int;

  periph_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_be(m0_be), .m1_be(m1_be), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .t_addr(t_addr), .t_wdata(t_wdata), .t_be(t_be), .t_we(t_we),
    .sel_dm(sel_dm), .sel_t0(sel_t0), .sel_t1(sel_t1), .sel_int(sel_int),
    .rd_dm(rd_dm), .rd_t0(rd_t0), .rd_t1(rd_t1), .rd_int(rd_int)
  );

`ifdef FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [3:0] LEGAL_BE [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
  localparam logic [1:0] LEGAL_LO [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  tgt;
    logic        err;
    logic [31:0] rdata;
    int unsigned scyc;
    int unsigned rcyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  bit          in_reset = 1'b1;
  bit          model_last = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
  endtask

  // Reference: decide outcome directly from the address map and legal lane table.
  function automatic exp_t model(input logic id, input req_t r, input int unsigned gcyc);
    exp_t e;
    bit legal = 1'b0;
    bit in_dm, in_t0, in_t1, in_int, cnt;
    for (int i = 0; i < 7; i++)
      if (r.be == LEGAL_BE[i] && r.addr[1:0] == LEGAL_LO[i]) legal = 1'b1;
    in_dm  = r.addr < 32'h3000;
    in_t0  = r.addr >= 32'h7F00 && r.addr <= 32'h7F0B;
    in_t1  = r.addr >= 32'h7F10 && r.addr <= 32'h7F1B;
    in_int = r.addr >= 32'h7F20 && r.addr <= 32'h7F23;
    cnt    = (r.addr >= 32'h7F08 && r.addr <= 32'h7F0B) || (r.addr >= 32'h7F18 && r.addr <= 32'h7F1B);
    e.id = id; e.we = r.we; e.addr = r.addr; e.wdata = r.wdata; e.be = r.be;
    e.err = !(in_dm || in_t0 || in_t1 || in_int) || !legal
         || (!in_dm && r.be != 4'hF) || (r.we && cnt);
    if (e.err)       e.tgt = 4'b0000;
    else if (in_dm)  e.tgt = 4'b0001;
    else if (in_t0)  e.tgt = 4'b0010;
    else if (in_t1)  e.tgt = 4'b0100;
    else             e.tgt = 4'b1000;
    if (e.err || r.we)        e.rdata = 32'h0;
    else if (e.tgt[0])        e.rdata = rd_dm;
    else if (e.tgt[1])        e.rdata = rd_t0;
    else if (e.tgt[2])        e.rdata = rd_t1;
    else                      e.rdata = rd_int;
    e.scyc = gcyc + 1;
    e.rcyc = gcyc + (e.err ? 1 : 2);
    return e;
  endfunction

  // Monitor: strobes and responses are compared against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        logic [3:0] sels;
        sels = {sel_int, sel_t1, sel_t0, sel_dm};
        if (q.size() == 0) begin
          if (sels != 0) check32("strobe_spurious", {28'h0, sels}, 32'h0);
          if (resp_valid) check32("resp_spurious", {31'h0, resp_valid}, 32'h0);
        end else begin
          exp_t e;
          e = q[0];
          if (sels != 0 || (e.tgt != 0 && cyc == e.scyc)) begin
            check32("strobe_sel", {28'h0, sels}, {28'h0, e.tgt});
            check32("strobe_cycle", cyc, e.scyc);
            check32("t_we", {31'h0, t_we}, {31'h0, e.we});
            check32("t_addr", t_addr, e.addr);
            check32("t_wdata", t_wdata, e.wdata);
            check32("t_be", {28'h0, t_be}, {28'h0, e.be});
          end
          if (resp_valid || cyc >= e.rcyc) begin
            void'(q.pop_front());
            check32("resp_valid", {31'h0, resp_valid}, 32'h1);
            check32("resp_cycle", cyc, e.rcyc);
            check32("resp_id", {31'h0, resp_id}, {31'h0, e.id});
            check32("resp_err", {31'h0, resp_err}, {31'h0, e.err});
            check32("resp_rdata", resp_rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic set_rd();
    rd_dm = $urandom; rd_t0 = $urandom; rd_t1 = $urandom; rd_int = $urandom;
  endtask

  task automatic drive(input bit id, input req_t r);
    if (id) begin m1_we = r.we; m1_addr = r.addr; m1_wdata = r.wdata; m1_be = r.be; end
    else    begin m0_we = r.we; m0_addr = r.addr; m0_wdata = r.wdata; m0_be = r.be; end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail("drain");
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic req_t mk(input bit we, input logic [31:0] addr, input logic [3:0] be);
    req_t r;
    r.we = we; r.addr = addr; r.be = be; r.wdata = $urandom;
    return r;
  endfunction

  // Issue one or two requests together; each is held until granted.
  task automatic run_group(input bit r0, input bit r1, input req_t p0, input req_t p1, output int first_wait);
    bit pend0 = r0, pend1 = r1, w;
    int budget = 0;
    first_wait = -1;
    drive(1'b0, p0); drive(1'b1, p1);
    m0_req = r0; m1_req = r1;
    while ((pend0 || pend1) && budget < 40) begin
      @(negedge clk);
      budget++;
      if (m0_gnt || m1_gnt) begin
        if (first_wait < 0) first_wait = budget - 1;
        w = (pend0 && pend1) ? (FIXED ? 1'b0 : !model_last) : pend1;
        check32("grant", {30'h0, m1_gnt, m0_gnt}, w ? 32'h2 : 32'h1);
        model_last = w;
        q.push_back(model(w, w ? p1 : p0, cyc));
        @(posedge clk); #1;
        if (w) begin m1_req = 1'b0; pend1 = 1'b0; end
        else   begin m0_req = 1'b0; pend0 = 1'b0; end
      end
    end
    if (pend0 || pend1) fail("grant_timeout");
    m0_req = 1'b0; m1_req = 1'b0;
    drain();
  endtask

  task automatic cont_test(input int n);
    int grants = 0, budget = 0;
    longint prev = -1;
    bit w;
    drive(1'b0, mk(1'b1, {18'h0, 12'($urandom_range(0, 32'hBFF)), 2'b00}, 4'hF));
    drive(1'b1, mk(1'b1, {18'h0, 12'($urandom_range(0, 32'hBFF)), 2'b00}, 4'hF));
    m0_req = 1'b1; m1_req = 1'b1;
    while (grants < n && budget < n * 3 + 10) begin
      @(negedge clk);
      budget++;
      if (m0_gnt || m1_gnt) begin
        w = FIXED ? 1'b0 : !model_last;
        check32("cont_grant", {30'h0, m1_gnt, m0_gnt}, w ? 32'h2 : 32'h1);
        if (prev >= 0) check32("cont_spacing", cyc - 32'(prev), 32'd3);
        prev = cyc;
        model_last = w;
        q.push_back(model(w, w ? '{m1_we, m1_addr, m1_wdata, m1_be} : '{m0_we, m0_addr, m0_wdata, m0_be}, cyc));
        grants++;
        @(posedge clk); #1;
        drive(w, mk(1'b1, {18'h0, 12'($urandom_range(0, 32'hBFF)), 2'b00}, 4'hF));
        if (grants == n) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
    end
    if (grants < n) fail("cont_timeout");
    m0_req = 1'b0; m1_req = 1'b0;
    drain();
  endtask

  function automatic req_t rand_req();
    req_t r;
    int k;
    r.we = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    case ($urandom_range(0, 5))
      0: r.addr = $urandom_range(0, 32'h2FFF);
      1: r.addr = 32'h7F00 + $urandom_range(0, 15);
      2: r.addr = 32'h7F10 + $urandom_range(0, 15);
      3: r.addr = 32'h7F20 + $urandom_range(0, 7);
      4: r.addr = $urandom;
      default: r.addr = 32'h2FFC + $urandom_range(0, 7);
    endcase
    k = $urandom_range(0, 9);
    if (k < 7) begin
      r.be = LEGAL_BE[k];
      if ($urandom_range(0, 3) != 0) r.addr[1:0] = LEGAL_LO[k];
    end else begin
      r.be = 4'($urandom);
    end
    return r;
  endfunction

  initial begin
    req_t p0, p1, idle_r;
    int fw;
    idle_r = mk(1'b0, 32'h0, 4'h0);
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    drive(1'b0, idle_r); drive(1'b1, idle_r);
    set_rd();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_sel", {28'h0, sel_int, sel_t1, sel_t0, sel_dm}, 32'h0);
    check32("rst_t_we", {31'h0, t_we}, 32'h0);
    check32("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check32("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check32("rst_resp_id", {31'h0, resp_id}, 32'h0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_t_addr", t_addr, 32'h0);
    check32("rst_t_wdata", t_wdata, 32'h0);
    check32("rst_t_be", {28'h0, t_be}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_reset = 1'b0;
    model_last = 1'b1;

    cont_test(6);

    set_rd(); rd_dm = 32'hDEADBEEF;
    run_group(1'b1, 1'b0, mk(1'b0, 32'h0000_0010, 4'hF), idle_r, fw);
    run_group(1'b0, 1'b1, idle_r, mk(1'b1, 32'h0000_7F08, 4'hF), fw);
    run_group(1'b1, 1'b0, mk(1'b1, 32'h0000_0102, 4'h3), idle_r, fw);
    run_group(1'b1, 1'b0, mk(1'b1, 32'h0000_0102, 4'hC), idle_r, fw);
    set_rd();
    run_group(1'b1, 1'b0, mk(1'b0, 32'h0000_3000, 4'hF), idle_r, fw);
    run_group(1'b1, 1'b0, mk(1'b0, 32'h0000_2FFC, 4'hF), idle_r, fw);
    run_group(1'b0, 1'b1, idle_r, mk(1'b0, 32'h0000_7F20, 4'hF), fw);
    run_group(1'b1, 1'b0, mk(1'b0, 32'h0000_7F1B, 4'h8), idle_r, fw);

    // A request raised and dropped while busy must leave no trace.
    drive(1'b0, mk(1'b0, 32'h0000_0040, 4'hF));
    m0_req = 1'b1;
    @(negedge clk);
    check32("busy_first_grant", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    model_last = 1'b0;
    q.push_back(model(1'b0, '{m0_we, m0_addr, m0_wdata, m0_be}, cyc));
    @(posedge clk); #1;
    m0_req = 1'b0;
    drive(1'b1, mk(1'b0, 32'h0000_0080, 4'hF));
    m1_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check32("gnt_while_busy", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    #1;

    // Reset during ACCESS discards the transaction.
    drive(1'b0, mk(1'b0, 32'h0000_0100, 4'hF));
    m0_req = 1'b1;
    @(negedge clk);
    check32("pre_reset_grant", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    in_reset = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check32("access_before_reset", {31'h0, sel_dm}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    in_reset = 1'b0;
    model_last = 1'b1;
    run_group(1'b1, 1'b1, mk(1'b0, 32'h0000_0200, 4'hF), mk(1'b0, 32'h0000_0204, 4'hF), fw);
    check32("grant_wait_after_reset", fw, 32'h0);

    for (int i = 0; i < 60; i++) begin
      int unsigned mask;
      mask = $urandom_range(1, 3);
      p0 = rand_req();
      p1 = rand_req();
      set_rd();
      run_group(mask[0], mask[1], p0, p1, fw);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
